// File: rtl/jk_monitor.sv
// ---------------------------------------------------------------------------
// jk_monitor
//
// Watches a jk_ff instance that shares this clock. Each cycle it predicts
// the flip-flop's next q from the previous cycle's j, k and q. It reports
// rising and falling edges of q, counts toggles and mismatches, and latches
// a sticky fault after ERR_LIMIT consecutive mismatches.
//
// Parameters:
//   CNT_W      width of toggle_cnt and err_cnt
//   ERR_LIMIT  consecutive mismatches in TRACK that force FAULT (1..255)
//
// Ports:
//   clk        rising-edge clock, shared with the observed jk_ff
//   rst        synchronous active-high reset
//   en         monitor enable
//   j, k, q    observed jk_ff inputs and output
//   state      IDLE=00, SYNC=01, TRACK=10, FAULT=11
//   rise/fall  one-cycle pulses on q edges seen in TRACK
//   toggle_cnt number of q changes seen in TRACK
//   mismatch   one-cycle pulse when q differs from the prediction
//   err_cnt    total mismatches, saturating at all-ones
//   fault      high exactly while state is FAULT
//
// Optional feature (compile-time macro):
//   JK_MON_TOGGLE_SAT_EN  when defined, toggle_cnt saturates instead of
//                         wrapping. err_cnt always saturates.
// ---------------------------------------------------------------------------
module jk_monitor #(
    parameter int CNT_W     = 8,
    parameter int ERR_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             j,
    input  logic             k,
    input  logic             q,
    output logic [1:0]       state,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fault
);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] SYNC  = 2'b01;
    localparam logic [1:0] TRACK = 2'b10;
    localparam logic [1:0] FAULT = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]       RUN_LIMIT = ERR_LIMIT[7:0];

    logic [1:0]       state_q, state_d;
    logic             jDly_q, kDly_q, qDly_q;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             mismatch_q, mismatch_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] toggleCnt_q, toggleCnt_d;
    logic [CNT_W-1:0] errCnt_q, errCnt_d;
    logic [7:0]       run_q, run_d;
    logic             expQ;

    // Prediction of q from the previous cycle's j/k/q. This follows the
    // standard JK table: hold, reset, set, toggle.
    always_comb begin
        expQ = qDly_q;
        case ({jDly_q, kDly_q})
            2'b00:   expQ = qDly_q;
            2'b01:   expQ = 1'b0;
            2'b10:   expQ = 1'b1;
            default: expQ = ~qDly_q;
        endcase
    end

    // Next-state logic for the FSM, the pulses and the counters.
    // Comparisons happen only in TRACK. SYNC exists so that the delayed
    // j/k/q hold one real cycle of history before the first check.
    // In TRACK a low en wins over the FAULT transition. The comparison for
    // that final cycle is still reported.
    always_comb begin
        state_d     = state_q;
        rise_d      = 1'b0;
        fall_d      = 1'b0;
        mismatch_d  = 1'b0;
        toggleCnt_d = toggleCnt_q;
        errCnt_d    = errCnt_q;
        run_d       = run_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = SYNC;
                end
            end
            SYNC: begin
                toggleCnt_d = '0;
                errCnt_d    = '0;
                run_d       = '0;
                state_d     = en ? TRACK : IDLE;
            end
            TRACK: begin
                if (q != expQ) begin
                    mismatch_d = 1'b1;
                    run_d      = run_q + 8'd1;
                    if (errCnt_q != {CNT_W{1'b1}}) begin
                        errCnt_d = errCnt_q + CNT_ONE;
                    end
                end else begin
                    run_d = '0;
                end
                if (q != qDly_q) begin
                    rise_d = q;
                    fall_d = ~q;
`ifdef JK_MON_TOGGLE_SAT_EN
                    if (toggleCnt_q != {CNT_W{1'b1}}) begin
                        toggleCnt_d = toggleCnt_q + CNT_ONE;
                    end
`else
                    toggleCnt_d = toggleCnt_q + CNT_ONE;
`endif
                end
                if (!en) begin
                    state_d = IDLE;
                end else if (run_d == RUN_LIMIT) begin
                    state_d = FAULT;
                end
            end
            default: begin
                // FAULT: counters and run stay frozen until en drops.
                if (!en) begin
                    state_d = IDLE;
                end
            end
        endcase
        fault_d = (state_d == FAULT);
    end

    // State and output registers. The input history registers sample every
    // cycle in every state, so history is valid once SYNC is reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            jDly_q      <= 1'b0;
            kDly_q      <= 1'b0;
            qDly_q      <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            mismatch_q  <= 1'b0;
            fault_q     <= 1'b0;
            toggleCnt_q <= '0;
            errCnt_q    <= '0;
            run_q       <= '0;
        end else begin
            state_q     <= state_d;
            jDly_q      <= j;
            kDly_q      <= k;
            qDly_q      <= q;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            mismatch_q  <= mismatch_d;
            fault_q     <= fault_d;
            toggleCnt_q <= toggleCnt_d;
            errCnt_q    <= errCnt_d;
            run_q       <= run_d;
        end
    end

    assign state      = state_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign mismatch   = mismatch_q;
    assign fault      = fault_q;
    assign toggle_cnt = toggleCnt_q;
    assign err_cnt    = errCnt_q;

endmodule

// File: doc/jk_monitor.md
# jk_monitor

Downstream checking stage for `jk_ff`. Observes the flip-flop's `j`, `k` inputs and `q` output on the shared clock, and predicts each next `q` from JK rules. Reports rise/fall edges, toggle count, per-cycle mismatches and a sticky fault once consecutive mismatches reach a limit. Used in DOE benches and on-board self-test beside any `jk_ff` instance.

## Interface
- `CNT_W`, 8: width of `toggle_cnt` and `err_cnt`.
- `ERR_LIMIT`, 4: consecutive TRACK mismatches that force FAULT; legal range 1..255.

Ports:
- `clk` input 1: single clock, rising edge; the same clock that drives the observed `jk_ff`.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: monitor enable.
- `j` input 1: J input of the observed `jk_ff`.
- `k` input 1: K input of the observed `jk_ff`.
- `q` input 1: Q output of the observed `jk_ff`.
- `state` output 2: IDLE=00, SYNC=01, TRACK=10, FAULT=11.
- `rise` output 1: one-cycle pulse on a 0→1 change of `q` while in TRACK.
- `fall` output 1: one-cycle pulse on a 1→0 change of `q` while in TRACK.
- `toggle_cnt` output CNT_W: count of `q` changes seen in TRACK.
- `mismatch` output 1: one-cycle pulse when `q` differs from the predicted value.
- `err_cnt` output CNT_W: total mismatches, saturating at all-ones.
- `fault` output 1: high exactly when `state`=FAULT.

## Operation
- Registers `j_d`, `k_d`, `q_d` capture `j`, `k`, `q` on every clock edge in all states.
- Predicted `q` (exp), computed combinationally from `j_d`, `k_d`, `q_d`:
  - 00 → `q_d`
  - 01 → 0
  - 10 → 1
  - 11 → ~`q_d`
- FSM transitions:
  - IDLE: if `en`=1, go to SYNC.
  - SYNC: clear `toggle_cnt`, `err_cnt` and the consecutive-mismatch counter `run`; go to TRACK if `en`=1, else IDLE. No comparison is made in SYNC, because `q_d` is not yet valid history.
  - TRACK: each cycle compare `q` with exp.
    - On mismatch: `mismatch`=1, `err_cnt`+1 (saturating), `run`+1.
    - On match: `run` cleared.
    - If `run` would reach ERR_LIMIT: go to FAULT.
    - If `en`=0: go to IDLE. `en`=0 has priority over the FAULT transition.
  - FAULT: outputs frozen, no counting. Leave only via `rst`, or `en`=0 → IDLE.
- Edges: `q` != `q_d` in TRACK → `rise` or `fall` by direction, and `toggle_cnt`+1.
- `toggle_cnt` wraps modulo 2^CNT_W; see Configuration for the alternative.
- In IDLE, `toggle_cnt` and `err_cnt` hold their last values so they can be read back; they clear only on the next entry to SYNC.
- An edge and a mismatch in the same cycle are both reported.

## Timing
- Reset values: `state`=00; `rise`, `fall`, `mismatch`, `fault`=0; `toggle_cnt`, `err_cnt`=0; `j_d`, `k_d`, `q_d`=0; `run`=0.
- All outputs are registered.
- A `jk_ff` transition caused by `j`, `k` at edge n appears on `q` after edge n. The monitor compares it at edge n+1, so flags are visible after edge n+1: one cycle of latency.
- `en` rising at edge n: SYNC after n, TRACK after n+1, first comparison at edge n+2.
- `rst` mid-operation: all registers return to reset values at that edge, regardless of state.

## Configuration
- `JK_MON_TOGGLE_SAT_EN`:
  - Defined: `toggle_cnt` saturates at 2^CNT_W−1.
  - Undefined (default): `toggle_cnt` wraps to 0.
- `err_cnt` always saturates, independent of the macro.

## Test plan
- Reset: `rst`=1 for 2 cycles with `en`=1, then observe → `state`=00, all flags and counters 0; SYNC begins one cycle after `rst` falls.
- Good toggle: behavioural `jk_ff` with `j`=`k`=1 for 10 TRACK cycles → `rise`/`fall` alternate, `toggle_cnt`=10, `mismatch` never 1, `err_cnt`=0.
- Stuck output: `j`=`k`=1 with `q` forced to 0 → `mismatch` every cycle, `err_cnt` 1,2,3,4. After the 4th mismatch, `state`=11 and `fault`=1; `err_cnt` holds at 4 for 5 more cycles.
- Hold and set/reset: `j`=`k`=0 for 5 cycles, then `j`=1,`k`=0, then `j`=0,`k`=1, with a good model → exactly one `rise` and one `fall`, `toggle_cnt`=2, `err_cnt`=0.
- Recovery: in FAULT, drop `en` for 1 cycle then raise it → IDLE, SYNC, TRACK; counters read 0 in TRACK; a good model then gives no mismatch.
- Counter width: `CNT_W`=4, 20 good toggles →
  - `toggle_cnt`=4 without `JK_MON_TOGGLE_SAT_EN`.
  - `toggle_cnt`=15 with it defined.
